sim_run_controller: RTL

SIM_RUN_CONTROLLER -- requirements
Module: sim_run_controller

---
 rtl/sim_run_controller.sv | 108 ++++++++++
 1 files changed

// File: rtl/sim_run_controller.sv
// Run sequencer: IDLE -> core reset hold -> RUN until a tohost write or cycle budget expiry.
// Every output comes from a flop loaded with the next-state decode; no inputs reach outputs combinationally.
module sim_run_controller #(
  parameter int unsigned MAX_CYCLES   = 100,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned CNT_W        = 32,
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_1000,
  parameter int unsigned N_CH         = 2
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             start,
  input  logic             mem_wr_ena,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wr_data,
  output logic [N_CH-1:0]  buttons,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [30:0]      exit_code,
  output logic [CNT_W-1:0] cycles,
  output logic             dump_strobe
);

  localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET_HOLD, S_RUN, S_PASS, S_FAIL, S_TIMEOUT
  } state_t;

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [CNT_W-1:0]  cycles_nxt;
  logic [30:0]       exit_nxt;
  logic              completion;
  logic              term_cur, term_nxt;

  assign completion = mem_wr_ena && (mem_addr == TOHOST_ADDR);
  assign term_cur   = (state == S_PASS) || (state == S_FAIL) || (state == S_TIMEOUT);
  assign term_nxt   = (state_nxt == S_PASS) || (state_nxt == S_FAIL) || (state_nxt == S_TIMEOUT);

  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    cycles_nxt = cycles;
    exit_nxt   = exit_code;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RESET_HOLD;
          hold_nxt  = '0;
        end
      end
      S_RESET_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nxt  = S_RUN;
          cycles_nxt = '0;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      S_RUN: begin
        // A completion write takes priority over the budget expiring in the same cycle.
        if (completion) begin
          state_nxt = (mem_wr_data == 32'd1) ? S_PASS : S_FAIL;
          exit_nxt  = mem_wr_data[31:1];
        end else begin
          cycles_nxt = cycles + 1'b1;
          if (cycles == CYC_LAST) state_nxt = S_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      cycles      <= '0;
      exit_code   <= '0;
      buttons     <= '0;
      running     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      dump_strobe <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      cycles      <= cycles_nxt;
      exit_code   <= exit_nxt;
      buttons     <= (state_nxt == S_RESET_HOLD) ? N_CH'(1) : '0;
      running     <= (state_nxt == S_RUN);
      done        <= term_nxt;
      pass        <= (state_nxt == S_PASS);
      fail        <= (state_nxt == S_FAIL);
      timeout     <= (state_nxt == S_TIMEOUT);
      dump_strobe <= term_nxt && !term_cur;
    end
  end

endmodule
